t02_wb_arbiter: RTL and testbench
=================================

# t02_wb_arbiter

Write-back arbiter and load scoreboard in front of the team's 32×32 register file. It shares the file's single write port between the ALU and memory-load result paths using round-robin valid/ready handshakes. It registers the granted write into one output stage that drives the file. It tracks outstanding loads in a busy vector and provides read-port forwarding plus a hazard flag to the decode/stall logic.

## Interface
- No parameters; 32 registers, 5-bit index, 32-bit data fixed.
- clk  in  1  clock
- nRST  in  1  reset; asynchronous, active-low
- alu_valid / alu_ready  in / out  1  ALU write-back handshake
- alu_index / alu_data  in  5 / 32  ALU destination, result
- mem_valid / mem_ready  in / out  1  load write-back handshake
- mem_index / mem_data  in  5 / 32  load destination, data
- ld_issue  in  1  a load is issued; reserve its destination
- ld_issue_index  in  5  destination of issued load
- read_index1, read_index2  in  5  decode read indices, also driven to file
- rf_read_data1, rf_read_data2  in  32  raw file read data
- read_data1, read_data2  out  32  forwarded read data
- hazard  out  1  a read index is busy (pending load)
- reg_write / write_index / write_data  out  1 / 5 / 32  to register file write port
- busy  out  32  scoreboard vector

## Operation
- Transfer: valid & ready on the same rising edge; at most one transfer per cycle.
- Eligibility: mem always eligible when valid. ALU eligible only if alu_valid and busy[alu_index]==0 (WAW order: ALU result must land after older load).
- Grant: one eligible requester gets ready. If both are eligible, the rr pointer decides (0 = ALU, 1 = mem). After any transfer, rr points to the other requester. ready is combinational; the non-granted ready is 0.
- Output stage: on transfer with index != 0, the next cycle has reg_write=1 and write_index/write_data = transferred values. Otherwise reg_write=0 and write_index/write_data hold.
- Index 0: the transfer is accepted (ready as normal, rr updates), but no reg_write is issued.
- Scoreboard set: ld_issue with ld_issue_index != 0 sets busy[idx] at the edge.
- Scoreboard clear: a mem transfer clears busy[mem_index] at the edge.
- Same-edge set and clear of one index: set wins.
- busy[0] is constant 0.
- Double issue to an already-busy index: busy stays 1. The first write-back clears it. The issuer must not have two loads outstanding to one register.
- Forwarding: read_dataN = write_data if reg_write & write_index==read_indexN & read_indexN!=0. Otherwise read_dataN = rf_read_dataN when read_indexN!=0, and 0 when read_indexN==0.
- hazard = (busy[read_index1] & read_index1!=0) | (busy[read_index2] & read_index2!=0), combinational.

## Timing
- Reset values: reg_write=0, write_index=0, write_data=0, busy=0, rr=0 (ALU preferred).
- While in reset, ready outputs follow the reset state: rr=0, busy=0.
- Reset mid-operation clears the output stage and scoreboard immediately. The pending write is lost.
- Latency: transfer at edge E → reg_write high in cycle E..E+1 → file captures at edge E+1 → rf_read_data valid from E+1. Forwarding covers cycle E..E+1.
- Load clear: mem transfer at edge E → hazard drops and forwarded data is available in the same cycle after E (zero bubble).
- A stalled ALU request to a busy register may be granted in the cycle after the clearing edge.
- Requesters must hold index/data stable while valid & !ready.

## Test plan
- Reset → busy=0, reg_write=0, alu_ready=1 when alu_valid=1 with idx 3 free.
- Both valid (alu idx5 data 0xAAAA, mem idx6 data 0xBBBB), held:
  - cycle 1: alu_ready=1, mem_ready=0;
  - cycle 2: mem_ready=1;
  - reg_write pulses idx5/0xAAAA, then idx6/0xBBBB.
- ld_issue idx7, read_index1=7:
  - hazard=1; alu_valid idx7 → alu_ready=0;
  - mem write-back idx7 data 0x1234 → next cycle hazard=0, read_data1=0x1234 via forward;
  - ALU then granted and writes 7 after.
- ALU write idx0 data 0xFFFFFFFF → alu_ready=1, reg_write stays 0; read_index2=0 → read_data2=0.
- ld_issue idx9 and mem transfer idx9 on the same edge → busy[9]=1 afterward.
- Assert nRST mid-stream with busy=0x0000_0280 and reg_write=1 → all outputs reset immediately; rr=0 after release.

Source files
------------

// File: rtl/t02_wb_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : t02_wb_arbiter                                           |
// | Description : Write-back arbiter and load scoreboard for the 32x32     |
// |               register file. Round-robin shares the single write port  |
// |               between ALU and load results, registers the granted      |
// |               write, tracks pending loads, forwards read data and      |
// |               raises a load-use hazard flag.                           |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module t02_wb_arbiter (
   input  logic        clk,
   input  logic        nRST,
   // ALU write-back requester
   input  logic        alu_valid,
   output logic        alu_ready,
   input  logic [4:0]  alu_index,
   input  logic [31:0] alu_data,
   // Load write-back requester
   input  logic        mem_valid,
   output logic        mem_ready,
   input  logic [4:0]  mem_index,
   input  logic [31:0] mem_data,
   // Load issue (scoreboard reservation)
   input  logic        ld_issue,
   input  logic [4:0]  ld_issue_index,
   // Decode read ports
   input  logic [4:0]  read_index1,
   input  logic [4:0]  read_index2,
   input  logic [31:0] rf_read_data1,
   input  logic [31:0] rf_read_data2,
   output logic [31:0] read_data1,
   output logic [31:0] read_data2,
   output logic        hazard,
   // Register file write port
   output logic        reg_write,
   output logic [4:0]  write_index,
   output logic [31:0] write_data,
   // Scoreboard
   output logic [31:0] busy
);

   // Round-robin pointer: 0 prefers ALU, 1 prefers mem.
   logic        rr;
   logic        alu_elig;
   logic        mem_elig;
   logic        alu_xfer;
   logic        mem_xfer;
   logic [31:0] set_mask;
   logic [31:0] clr_mask;

   // Eligibility and grant; an ALU result waits behind an older pending load
   // to the same register so the write order stays correct.
   always_comb begin
      alu_elig  = alu_valid & ~busy[alu_index];
      mem_elig  = mem_valid;
      alu_ready = alu_elig & (~mem_elig | ~rr);
      mem_ready = mem_elig & (~alu_elig | rr);
      alu_xfer  = alu_ready;
      mem_xfer  = mem_ready;
   end

   // Scoreboard set/clear masks for this edge; register 0 is never reserved.
   always_comb begin
      set_mask = '0;
      clr_mask = '0;
      if (ld_issue && (ld_issue_index != 5'd0)) begin
         set_mask[ld_issue_index] = 1'b1;
      end
      if (mem_xfer) begin
         clr_mask[mem_index] = 1'b1;
      end
   end

   // Pointer flips to the other requester after every transfer.
   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         rr <= 1'b0;
      end else if (alu_xfer) begin
         rr <= 1'b1;
      end else if (mem_xfer) begin
         rr <= 1'b0;
      end
   end

   // Busy vector: a set on the same edge as a clear wins; bit 0 stays 0.
   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         busy <= '0;
      end else begin
         busy <= ((busy & ~clr_mask) | set_mask) & ~32'd1;
      end
   end

   // Output stage: one-cycle write pulse; index/data hold between writes.
   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         reg_write   <= 1'b0;
         write_index <= '0;
         write_data  <= '0;
      end else begin
         reg_write <= 1'b0;
         if (alu_xfer && (alu_index != 5'd0)) begin
            reg_write   <= 1'b1;
            write_index <= alu_index;
            write_data  <= alu_data;
         end else if (mem_xfer && (mem_index != 5'd0)) begin
            reg_write   <= 1'b1;
            write_index <= mem_index;
            write_data  <= mem_data;
         end
      end
   end

   // Read forwarding covers the cycle before the file has captured the write.
   always_comb begin
      if (reg_write && (write_index == read_index1) && (read_index1 != 5'd0)) begin
         read_data1 = write_data;
      end else if (read_index1 != 5'd0) begin
         read_data1 = rf_read_data1;
      end else begin
         read_data1 = '0;
      end

      if (reg_write && (write_index == read_index2) && (read_index2 != 5'd0)) begin
         read_data2 = write_data;
      end else if (read_index2 != 5'd0) begin
         read_data2 = rf_read_data2;
      end else begin
         read_data2 = '0;
      end

      hazard = (busy[read_index1] & (read_index1 != 5'd0)) |
               (busy[read_index2] & (read_index2 != 5'd0));
   end

endmodule
`default_nettype wire

// File: tb/tb_t02_wb_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_t02_wb_arbiter                                        |
// | Description : Self-checking bench for t02_wb_arbiter: reset-time       |
// |               vector table plus write-back scoreboard sequences.       |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module tb_t02_wb_arbiter;

   logic        clk = 1'b0;
   logic        nRST = 1'b1;
   logic        alu_valid = 1'b0;
   logic        alu_ready;
   logic [4:0]  alu_index = '0;
   logic [31:0] alu_data = '0;
   logic        mem_valid = 1'b0;
   logic        mem_ready;
   logic [4:0]  mem_index = '0;
   logic [31:0] mem_data = '0;
   logic        ld_issue = 1'b0;
   logic [4:0]  ld_issue_index = '0;
   logic [4:0]  read_index1 = '0;
   logic [4:0]  read_index2 = '0;
   logic [31:0] rf_read_data1 = '0;
   logic [31:0] rf_read_data2 = '0;
   logic [31:0] read_data1;
   logic [31:0] read_data2;
   logic        hazard;
   logic        reg_write;
   logic [4:0]  write_index;
   logic [31:0] write_data;
   logic [31:0] busy;

   int n_total = 0;
   int n_pass  = 0;

   typedef struct {
      logic [4:0]  idx;
      logic [31:0] data;
   } wb_t;
   wb_t sb[$];

   typedef struct {
      logic        av;
      logic [4:0]  ai;
      logic        mv;
      logic [4:0]  ri1;
      logic [4:0]  ri2;
      logic [31:0] rf1;
      logic [31:0] rf2;
      logic        ear;
      logic        emr;
      logic [31:0] erd1;
      logic [31:0] erd2;
   } vec_t;
   vec_t vecs[5];

   t02_wb_arbiter dut (
      .clk            (clk),
      .nRST           (nRST),
      .alu_valid      (alu_valid),
      .alu_ready      (alu_ready),
      .alu_index      (alu_index),
      .alu_data       (alu_data),
      .mem_valid      (mem_valid),
      .mem_ready      (mem_ready),
      .mem_index      (mem_index),
      .mem_data       (mem_data),
      .ld_issue       (ld_issue),
      .ld_issue_index (ld_issue_index),
      .read_index1    (read_index1),
      .read_index2    (read_index2),
      .rf_read_data1  (rf_read_data1),
      .rf_read_data2  (rf_read_data2),
      .read_data1     (read_data1),
      .read_data2     (read_data2),
      .hazard         (hazard),
      .reg_write      (reg_write),
      .write_index    (write_index),
      .write_data     (write_data),
      .busy           (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [4:0] idx, input logic [31:0] data);
      wb_t e;
      e.idx  = idx;
      e.data = data;
      sb.push_back(e);
   endtask

   // Scoreboard monitor: every write pulse must match the oldest expected write.
   always @(negedge clk) begin
      if (nRST === 1'b1 && reg_write === 1'b1) begin
         if (sb.size() == 0) begin
            n_total++;
            $display("FAIL sb_unexpected: got write idx %0d data 0x%0h, expected no write",
                     write_index, write_data);
         end else begin
            wb_t e;
            e = sb.pop_front();
            check("sb_index", {27'd0, write_index}, {27'd0, e.idx});
            check("sb_data", write_data, e.data);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("%0d/%0d checks passed", n_pass, n_total + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      //           av    ai     mv    ri1    ri2    rf1           rf2           ear   emr   erd1          erd2
      vecs[0] = '{1'b1, 5'd3,  1'b0, 5'd3,  5'd0,  32'h11,       32'h22,       1'b1, 1'b0, 32'h11,       32'h0};
      vecs[1] = '{1'b0, 5'd0,  1'b1, 5'd0,  5'd31, 32'hFFFFFFFF, 32'hCAFE,     1'b0, 1'b1, 32'h0,        32'hCAFE};
      vecs[2] = '{1'b1, 5'd0,  1'b1, 5'd1,  5'd2,  32'hA5A5A5A5, 32'h5A5A5A5A, 1'b1, 1'b0, 32'hA5A5A5A5, 32'h5A5A5A5A};
      vecs[3] = '{1'b0, 5'd0,  1'b0, 5'd31, 5'd31, 32'h1,        32'h2,        1'b0, 1'b0, 32'h1,        32'h2};
      vecs[4] = '{1'b1, 5'd31, 1'b1, 5'd0,  5'd0,  32'hFF,       32'hFF,       1'b1, 1'b0, 32'h0,        32'h0};

      #1 nRST = 1'b0;
      #1;
      check("rst_busy", busy, 32'h0);
      check("rst_reg_write", {31'd0, reg_write}, 32'd0);
      check("rst_write_index", {27'd0, write_index}, 32'd0);
      check("rst_write_data", write_data, 32'd0);

      // Combinational paths while held in reset (rr=0, busy=0, no write).
      for (int i = 0; i < 5; i++) begin
         alu_valid     = vecs[i].av;
         alu_index     = vecs[i].ai;
         mem_valid     = vecs[i].mv;
         read_index1   = vecs[i].ri1;
         read_index2   = vecs[i].ri2;
         rf_read_data1 = vecs[i].rf1;
         rf_read_data2 = vecs[i].rf2;
         #2;
         check("vec_alu_ready", {31'd0, alu_ready}, {31'd0, vecs[i].ear});
         check("vec_mem_ready", {31'd0, mem_ready}, {31'd0, vecs[i].emr});
         check("vec_read_data1", read_data1, vecs[i].erd1);
         check("vec_read_data2", read_data2, vecs[i].erd2);
         check("vec_hazard", {31'd0, hazard}, 32'd0);
      end
      alu_valid   = 1'b0;
      mem_valid   = 1'b0;
      read_index1 = '0;
      read_index2 = '0;

      @(negedge clk) nRST = 1'b1;
      tick;

      // Both requesters valid and held: ALU first, then mem.
      alu_valid = 1'b1; alu_index = 5'd5; alu_data = 32'hAAAA;
      mem_valid = 1'b1; mem_index = 5'd6; mem_data = 32'hBBBB;
      #1;
      check("both_c1_alu_ready", {31'd0, alu_ready}, 32'd1);
      check("both_c1_mem_ready", {31'd0, mem_ready}, 32'd0);
      push(5'd5, 32'hAAAA);
      tick;
      check("both_c2_alu_ready", {31'd0, alu_ready}, 32'd0);
      check("both_c2_mem_ready", {31'd0, mem_ready}, 32'd1);
      push(5'd6, 32'hBBBB);
      tick;
      alu_valid = 1'b0; mem_valid = 1'b0;
      read_index1 = 5'd5; rf_read_data1 = 32'h5555;
      read_index2 = 5'd6; rf_read_data2 = 32'h6666;
      #1;
      check("fwd_file_rd1", read_data1, 32'h5555);
      check("fwd_wb_rd2", read_data2, 32'hBBBB);

      // Load-use hazard, stalled ALU write to the busy register, zero-bubble clear.
      ld_issue = 1'b1; ld_issue_index = 5'd7;
      tick;
      ld_issue = 1'b0;
      read_index1 = 5'd7; rf_read_data1 = 32'hDEAD;
      read_index2 = 5'd0;
      #1;
      check("ld_hazard_set", {31'd0, hazard}, 32'd1);
      check("ld_busy_set", busy, 32'h80);
      alu_valid = 1'b1; alu_index = 5'd7; alu_data = 32'h7777;
      #1;
      check("waw_alu_stalled", {31'd0, alu_ready}, 32'd0);
      tick;
      mem_valid = 1'b1; mem_index = 5'd7; mem_data = 32'h1234;
      #1;
      check("ld_mem_ready", {31'd0, mem_ready}, 32'd1);
      check("ld_alu_still_stalled", {31'd0, alu_ready}, 32'd0);
      push(5'd7, 32'h1234);
      tick;
      mem_valid = 1'b0;
      #1;
      check("ld_hazard_clear", {31'd0, hazard}, 32'd0);
      check("ld_fwd_rd1", read_data1, 32'h1234);
      check("ld_busy_clear", busy, 32'h0);
      check("waw_alu_granted", {31'd0, alu_ready}, 32'd1);
      push(5'd7, 32'h7777);
      tick;
      alu_valid = 1'b0;
      #1;
      check("waw_fwd_rd1", read_data1, 32'h7777);

      // Index-0 write: accepted, no write pulse, pointer still advances.
      mem_valid = 1'b1; mem_index = 5'd11; mem_data = 32'hB;
      #1;
      check("m11_mem_ready", {31'd0, mem_ready}, 32'd1);
      push(5'd11, 32'hB);
      tick;
      mem_valid = 1'b0;
      alu_valid = 1'b1; alu_index = 5'd0; alu_data = 32'hFFFFFFFF;
      #1;
      check("idx0_alu_ready", {31'd0, alu_ready}, 32'd1);
      tick;
      alu_valid = 1'b0;
      read_index2 = 5'd0; rf_read_data2 = 32'h12345678;
      #1;
      check("idx0_no_write", {31'd0, reg_write}, 32'd0);
      check("idx0_hold_index", {27'd0, write_index}, 32'd11);
      check("idx0_hold_data", write_data, 32'hB);
      check("idx0_rd2_zero", read_data2, 32'h0);
      alu_valid = 1'b1; alu_index = 5'd10; alu_data = 32'hA;
      mem_valid = 1'b1; mem_index = 5'd12; mem_data = 32'hC;
      #1;
      check("rr_after_idx0_mem", {31'd0, mem_ready}, 32'd1);
      check("rr_after_idx0_alu", {31'd0, alu_ready}, 32'd0);
      push(5'd12, 32'hC);
      tick;
      mem_valid = 1'b0;
      #1;
      check("rr_alu_next", {31'd0, alu_ready}, 32'd1);
      push(5'd10, 32'hA);
      tick;
      alu_valid = 1'b0;

      // Same-edge issue and write-back to one register: set wins.
      ld_issue = 1'b1; ld_issue_index = 5'd9;
      mem_valid = 1'b1; mem_index = 5'd9; mem_data = 32'h99;
      #1;
      check("same_edge_mem_ready", {31'd0, mem_ready}, 32'd1);
      push(5'd9, 32'h99);
      tick;
      ld_issue = 1'b0; mem_valid = 1'b0;
      read_index2 = 5'd9;
      #1;
      check("same_edge_busy", busy, 32'h200);
      check("same_edge_hazard", {31'd0, hazard}, 32'd1);
      check("same_edge_fwd_rd2", read_data2, 32'h99);

      // Asynchronous reset mid-stream discards pending write and scoreboard.
      ld_issue = 1'b1; ld_issue_index = 5'd7;
      alu_valid = 1'b1; alu_index = 5'd4; alu_data = 32'h44;
      #1;
      check("pre_rst_alu_ready", {31'd0, alu_ready}, 32'd1);
      tick;
      ld_issue = 1'b0; alu_valid = 1'b0;
      #1;
      check("pre_rst_busy", busy, 32'h280);
      check("pre_rst_reg_write", {31'd0, reg_write}, 32'd1);
      nRST = 1'b0;
      #1;
      check("mid_rst_reg_write", {31'd0, reg_write}, 32'd0);
      check("mid_rst_busy", busy, 32'h0);
      check("mid_rst_write_index", {27'd0, write_index}, 32'd0);
      check("mid_rst_write_data", write_data, 32'd0);
      check("mid_rst_hazard", {31'd0, hazard}, 32'd0);
      @(negedge clk);
      @(negedge clk) nRST = 1'b1;
      tick;
      alu_valid = 1'b1; alu_index = 5'd1; alu_data = 32'h101;
      mem_valid = 1'b1; mem_index = 5'd2; mem_data = 32'h202;
      #1;
      check("post_rst_alu_ready", {31'd0, alu_ready}, 32'd1);
      check("post_rst_mem_ready", {31'd0, mem_ready}, 32'd0);
      push(5'd1, 32'h101);
      tick;
      alu_valid = 1'b0;
      #1;
      check("post_rst_mem_next", {31'd0, mem_ready}, 32'd1);
      push(5'd2, 32'h202);
      tick;
      mem_valid = 1'b0;
      tick;
      tick;
      check("sb_drained", sb.size(), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
